// File: rtl/mul_share_arb_pkg.sv
// Shared constants, tag type and phase enum for the multiplier-sharing arbiter.
package mul_share_arb_pkg;

  localparam int unsigned N_DEF   = 10;
  localparam int unsigned K_DEF   = 4;
  localparam int unsigned LAT_DEF = 2;

  // Width of a requester id for k requesters (k is at least 2).
  function automatic int unsigned id_width(input int unsigned k);
    return (k <= 2) ? 1 : $clog2(k);
  endfunction

  // Sized for the largest supported K so the tag type is fixed across builds.
  localparam int unsigned IDW = id_width(8);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  typedef enum logic {StIdle, StRun} phase_e;

endpackage

// File: rtl/mul_share_arb_rr.sv
// Round-robin grant: first asserted request at or after ptr, wrapping modulo K.
module rr_arbiter_k #(
  parameter int unsigned K  = 4,
  parameter int unsigned PW = 3
) (
  input  logic [K-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [K-1:0]  gnt
);

  logic found;

  // Scan offsets in priority order; only constant indices touch req/gnt.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int off = 0; off < int'(K); off++) begin
      for (int i = 0; i < int'(K); i++) begin
        if (!found && req[i] && (((int'(ptr) + off) % int'(K)) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one pipelined multiplier between K requesters with round-robin issue.
// Optional per-requester grant counters: define MUL_SHARE_ARB_PERF_EN.
module mul_share_arb
  import mul_share_arb_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned K   = K_DEF,
  parameter int unsigned LAT = LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [K-1:0]      req_valid,
  output logic [K-1:0]      req_ready,
  input  logic [K*N-1:0]    req_x,
  input  logic [K*N-1:0]    req_y,
  output logic [K-1:0]      rsp_valid,
  output logic [2*N-1:0]    rsp_z,
  output logic [N-1:0]      mul_x,
  output logic [N-1:0]      mul_y,
  input  logic [2*N-1:0]    mul_z,
  output logic [K-1:0]      busy,
  output logic [16*K-1:0]   perf_cnt
);

  logic [K-1:0]   elig, gnt;
  logic [K-1:0]   busy_q, busy_d;
  logic [K-1:0]   rsp_valid_q, rsp_valid_d;
  logic [2*N-1:0] rsp_z_q, rsp_z_d;
  logic [N-1:0]   mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic [IDW-1:0] ptr_q, ptr_d, gnt_id;
  phase_e         st_q, st_d;

  // Stage 0 travels alongside mul_x/mul_y; stages 1..LAT follow the multiplier.
  tag_t tag_q [LAT+1];
  tag_t tag_d [LAT+1];

  assign elig = req_valid & ~busy_q;

  rr_arbiter_k #(
    .K  (K),
    .PW (IDW)
  ) u_arb (
    .req (elig),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign req_ready = gnt;

  // Encode the grant, select its operands and advance the pointer past it.
  always_comb begin
    gnt_id  = '0;
    mul_x_d = mul_x_q;
    mul_y_d = mul_y_q;
    for (int i = 0; i < int'(K); i++) begin
      if (gnt[i]) begin
        gnt_id  = IDW'(i);
        mul_x_d = req_x[i*N +: N];
        mul_y_d = req_y[i*N +: N];
      end
    end
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = (gnt_id == IDW'(K - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // Tag shift register, response routing, busy bookkeeping and global phase.
  always_comb begin
    tag_d[0].vld = |gnt;
    tag_d[0].id  = gnt_id;
    for (int s = 1; s <= int'(LAT); s++) begin
      tag_d[s] = tag_q[s-1];
    end

    rsp_valid_d = '0;
    rsp_z_d     = rsp_z_q;
    busy_d      = busy_q;
    if (tag_q[LAT].vld) begin
      rsp_z_d = mul_z;
      for (int i = 0; i < int'(K); i++) begin
        if (tag_q[LAT].id == IDW'(i)) begin
          rsp_valid_d[i] = 1'b1;
          busy_d[i]      = 1'b0;
        end
      end
    end
    // A retiring requester is busy until this edge, so it cannot also be granted here.
    busy_d = busy_d | gnt;

    st_d = StIdle;
    if (|gnt) st_d = StRun;
    for (int s = 0; s < int'(LAT); s++) begin
      if (tag_q[s].vld) st_d = StRun;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      rsp_valid_q <= '0;
      rsp_z_q     <= '0;
      busy_q      <= '0;
      ptr_q       <= '0;
      st_q        <= StIdle;
      for (int s = 0; s <= int'(LAT); s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      st_q        <= st_d;
      for (int s = 0; s <= int'(LAT); s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  // Busy is only ever set while work is in flight; idle phase forces it low.
  assign busy      = (st_q == StRun) ? busy_q : '0;

`ifdef MUL_SHARE_ARB_PERF_EN
  logic [15:0] cnt_q [K];

  // Saturating per-requester acceptance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(K); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(K); i++) begin
        if (gnt[i] && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  // Pack counters onto the output bus.
  always_comb begin
    perf_cnt = '0;
    for (int i = 0; i < int'(K); i++) perf_cnt[16*i +: 16] = cnt_q[i];
  end
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one pipelined cascade multiplier (x, y, clk -> z, latency LAT) between K requesters.
- Round-robin arbitration, at most one operand pair issued per cycle.
- Each grant carries a tag through a shift register matched to the multiplier latency, so each product is routed back to its requester.
- Sits between operand-producing clients and the multiplier instance. The multiplier is external and connected through the mul_* ports.

Parameters:
- N, 10, operand width; product is 2N bits
- K, 4, number of requesters (2..8)
- LAT, 2, multiplier latency: edges from operands registered on mul_x/mul_y to the matching mul_z being valid

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  K  per-requester operand valid
- req_ready  out  K  per-requester accept
- req_x  in  K*N  packed operands x, requester i at [i*N +: N]
- req_y  in  K*N  packed operands y, same packing
- rsp_valid  out  K  one-hot, one-cycle product valid
- rsp_z  out  2N  product for the requester flagged in rsp_valid
- mul_x  out  N  registered operand to multiplier
- mul_y  out  N  registered operand to multiplier
- mul_z  in  2N  multiplier product
- busy  out  K  requester has a product in flight
- perf_cnt  out  16*K  per-requester grant counters (optional feature)

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values:
  - mul_x = 0, mul_y = 0, rsp_valid = 0, rsp_z = 0, busy = 0.
  - Round-robin pointer = 0; tag pipeline cleared; perf_cnt = 0.
- Eligibility: requester i is eligible when req_valid[i] & ~busy[i].
- Grant:
  - Search eligible requesters starting at the pointer, wrapping modulo K; grant the first one found.
  - req_ready[i] = grant[i]. It is combinational from req_valid and is one-hot or zero.
  - Clients must not derive req_valid from req_ready.
- Acceptance edge (req_valid[i] & req_ready[i]):
  - mul_x <= req_x[i], mul_y <= req_y[i].
  - busy[i] <= 1.
  - Tag stage 0 <= {valid = 1, id = i}.
  - Pointer <= (i+1) mod K.
- No grant: mul_x/mul_y hold their values; tag stage 0 valid = 0; pointer holds.
- Tag pipeline:
  - LAT stages, shifting every cycle; no stall path exists.
  - When the final stage is valid, on the next edge: rsp_valid <= onehot(id), rsp_z <= mul_z, busy[id] <= 0.
  - Otherwise rsp_valid <= 0 and rsp_z holds.
- Latency:
  - rsp_valid rises exactly LAT+1 edges after the acceptance edge and stays high for one cycle.
  - Responses return in grant order. Peak throughput is 1 product per cycle across requesters.
- One outstanding operation per requester. Simultaneous clear and re-grant is legal:
  - busy[i] clears on the edge where rsp_valid[i] goes high.
  - In that cycle, requester i is eligible again and may be accepted.
- Arithmetic: no truncation. rsp_z = mul_z, the full 2N-bit product.
- Reset mid-operation: all in-flight tags are discarded, no rsp_valid is produced for them, busy clears and the pointer returns to 0.
- State machine (global phase, exported only through busy):
  - IDLE: no tags valid, busy = 0.
  - RUN: at least one tag valid.
  - IDLE -> RUN on any grant. RUN -> IDLE when the last valid tag retires with no grant that cycle.

Optional Feature:
- Macro: MUL_SHARE_ARB_PERF_EN.
- Defined:
  - perf_cnt[16*i +: 16] increments on each acceptance edge for requester i.
  - Counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: perf_cnt is tied to 0 and no counter flops are synthesised.

Decomposition:
- Package mul_share_arb_pkg holds:
  - default constants N_DEF = 10, K_DEF = 4, LAT_DEF = 2
  - id width function clog2(K)
  - typedef struct packed {logic vld; logic [IDW-1:0] id;} tag_t
- Sub-module rr_arbiter_k:
  - Pure round-robin grant logic.
  - Inputs: request vector, pointer. Output: one-hot grant.
  - Instanced once. Pointer register stays in the parent.

Test Plan (N=10, K=4, LAT=2, multiplier model with 2-cycle latency):
- Single request: r1 valid with x=3, y=5 at idle -> accepted at edge E0; busy[1]=1; rsp_valid=4'b0010 and rsp_z=15 after edge E3 for exactly one cycle; busy[1]=0 after E3.
- All four requesters valid the cycle after reset, operands (x,y) = (2,3), (4,5), (6,7), (8,9) -> grants in order 0,1,2,3 on consecutive cycles; rsp_z = 6, 20, 42, 72 on consecutive cycles with one-hot rsp_valid matching.
- Fairness: r0 and r2 permanently valid after their responses return -> grants never repeat the same requester while the other is eligible; r1 and r3 are never granted.
- Busy/re-grant: r3 holds req_valid high continuously -> req_ready[3]=0 for the 3 cycles after acceptance; re-accepted in the same cycle rsp_valid[3] is high.
- Width boundary: x=1023, y=1023 -> rsp_z=1046529 (20'hFF801), no truncation.
- Reset mid-flight: grant r2, assert rst one cycle after acceptance -> no rsp_valid ever appears; busy=0; next grant with all four requesters valid goes to r0. With MUL_SHARE_ARB_PERF_EN defined, perf_cnt reads 0.
